// File: rtl/dbx_sched_pkg.sv
// dbx_sched_pkg: default sizing, scheduler state, in-flight tile tag and index-width helper
package dbx_sched_pkg;
  localparam int DEF_H = 24;
  localparam int DEF_P = 64;
  localparam int DEF_N = 128;
  localparam int DEF_H_TILE = 1;
  localparam int DEF_P_TILE = 1;
  localparam int DEF_N_TILE = 32;
  localparam int DEF_M_LAT = 6;
  localparam int DEF_CREDITS = 8;
  localparam int IW = 16;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;
  typedef struct packed {
    logic [IW-1:0] h;
    logic [IW-1:0] p;
    logic [IW-1:0] n;
    logic          last;
  } tag_t;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/dbx_tag_fifo.sv
// dbx_tag_fifo: sync FIFO (clk, rstn, push/wr_data, pop/rd_data, full/empty); push when full and pop when empty are ignored
module dbx_tag_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push,
  input  logic [W-1:0] wr_data,
  input  logic         pop,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  always_comb begin
    full = cnt_q == CW'(DEPTH);
    empty = cnt_q == '0;
    do_push = push && !full;
    do_pop = pop && !empty;
    wr_d = do_push ? (wr_q == AW'(DEPTH - 1) ? '0 : wr_q + AW'(1)) : wr_q;
    rd_d = do_pop ? (rd_q == AW'(DEPTH - 1) ? '0 : rd_q + AW'(1)) : rd_q;
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end
  assign rd_data = mem_q[rd_q];
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= wr_data;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/dbx_tile_sched.sv
// dbx_tile_sched: dBx tile sequencer; start_i/busy_o/done_o control, rd_en_o+dx/b addresses, mul_valid_o/i multiplier handshake, tagged out_*, credit_ret_i flow control, sticky err_o
module dbx_tile_sched import dbx_sched_pkg::*; #(
  parameter  int H       = DEF_H,
  parameter  int P       = DEF_P,
  parameter  int N       = DEF_N,
  parameter  int H_TILE  = DEF_H_TILE,
  parameter  int P_TILE  = DEF_P_TILE,
  parameter  int N_TILE  = DEF_N_TILE,
  parameter  int M_LAT   = DEF_M_LAT,
  parameter  int CREDITS = DEF_CREDITS,
  localparam int NH      = H / H_TILE,
  localparam int NP      = P / P_TILE,
  localparam int NN      = N / N_TILE,
  localparam int HW      = idx_w(NH),
  localparam int PW      = idx_w(NP),
  localparam int NW      = idx_w(NN),
  localparam int DXW     = idx_w(NH * NP),
  localparam int CW      = $clog2(CREDITS + 1)
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           start_i,
  output logic           busy_o,
  output logic           done_o,
  output logic           rd_en_o,
  output logic [DXW-1:0] dx_addr_o,
  output logic [NW-1:0]  b_addr_o,
  output logic           mul_valid_o,
  input  logic           mul_valid_i,
  output logic           out_valid_o,
  output logic [HW-1:0]  out_h_o,
  output logic [PW-1:0]  out_p_o,
  output logic [NW-1:0]  out_n_o,
  output logic           out_last_o,
  input  logic           credit_ret_i,
  output logic           err_o
);
  state_e state_q, state_d;
  logic [HW-1:0] h_q, h_d;
  logic [PW-1:0] p_q, p_d;
  logic [NW-1:0] n_q, n_d;
  logic [CW-1:0] credit_q, credit_d;
  tag_t tag_q, tag_d, fifo_rd, head;
  logic mul_valid_q, mul_valid_d, err_q, err_d;
  logic issue, n_wrap, p_wrap, last_tile, credit_sat, fifo_full, fifo_empty;
  // tags enter one cycle after issue, together with mul_valid_o, so FIFO order matches multiplier order
  dbx_tag_fifo #(.W($bits(tag_t)), .DEPTH(M_LAT + 2)) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push    (mul_valid_q),
    .wr_data (tag_q),
    .pop     (mul_valid_i),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );
  always_comb begin
    n_wrap = n_q == NW'(NN - 1);
    p_wrap = p_q == PW'(NP - 1);
    last_tile = n_wrap && p_wrap && h_q == HW'(NH - 1);
    issue = state_q == RUN && credit_q != '0;
    credit_sat = credit_ret_i && !issue && credit_q == CW'(CREDITS);
    done_o = state_q == DRAIN && !mul_valid_q && fifo_empty;
    state_d = state_q == IDLE && start_i ? RUN : issue && last_tile ? DRAIN : done_o ? IDLE : state_q;
    n_d = state_q == IDLE ? '0 : issue ? (n_wrap ? '0 : n_q + NW'(1)) : n_q;
    p_d = state_q == IDLE ? '0 : issue && n_wrap ? (p_wrap ? '0 : p_q + PW'(1)) : p_q;
    h_d = state_q == IDLE ? '0 : issue && n_wrap && p_wrap ? (last_tile ? '0 : h_q + HW'(1)) : h_q;
    credit_d = credit_sat ? credit_q : credit_q - CW'(issue) + CW'(credit_ret_i);
    tag_d = issue ? tag_t'{h: IW'(h_q), p: IW'(p_q), n: IW'(n_q), last: last_tile} : tag_q;
    mul_valid_d = issue;
    err_d = err_q | credit_sat | (mul_valid_q & fifo_full) | (mul_valid_i & fifo_empty);
    head = fifo_empty ? '0 : fifo_rd;
  end
  assign busy_o = state_q != IDLE;
  assign rd_en_o = issue;
  assign dx_addr_o = DXW'(int'(h_q) * NP + int'(p_q));
  assign b_addr_o = n_q;
  assign mul_valid_o = mul_valid_q;
  assign out_valid_o = mul_valid_i;
  assign out_h_o = HW'(head.h);
  assign out_p_o = PW'(head.p);
  assign out_n_o = NW'(head.n);
  assign out_last_o = head.last;
  assign err_o = err_q;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      h_q <= '0;
      p_q <= '0;
      n_q <= '0;
      credit_q <= CW'(CREDITS);
      tag_q <= '0;
      mul_valid_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q <= h_d;
      p_q <= p_d;
      n_q <= n_d;
      credit_q <= credit_d;
      tag_q <= tag_d;
      mul_valid_q <= mul_valid_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_dbx_tile_sched.sv
// tb_dbx_tile_sched: tile-index model with credit/phase tracking plus directed sweeps for dbx_tile_sched
module tb_dbx_tile_sched;
  localparam int H = 2, P = 2, N = 64, N_TILE = 32, M_LAT = 6, CREDITS = 8;
  localparam int NH = H, NP = P, NN = N / N_TILE, T = NH * NP * NN;
  typedef struct {int h; int p; int n; int last;} tag_s;
  logic clk = 0, rstn = 0, start_i = 0, man_ret = 0, auto_ret = 0, spur = 0;
  logic busy_o, done_o, rd_en_o, mul_valid_o, mul_valid_i, out_valid_o, out_last_o, credit_ret_i, err_o;
  logic [1:0] dx_addr_o;
  logic [0:0] b_addr_o, out_h_o, out_p_o, out_n_o;
  logic [M_LAT-1:0] pipe;
  int checks = 0, fails = 0, cyc = 0;
  int n_iss = 0, n_done = 0, n_out = 0, last_idx = -1, done_lat = -1, start_cyc = 0;
  int iss_dx[$], iss_b[$];
  int exp_dx[8] = '{0, 0, 1, 1, 2, 2, 3, 3};
  int exp_b[8] = '{0, 1, 0, 1, 0, 1, 0, 1};
  int mphase = 0, k = 0, credits = CREDITS, prev_iss = 0, merr = 0;
  int exp_rd, exp_done;
  tag_s q[$];
  tag_s tg;
  dbx_tile_sched #(.H(H), .P(P), .N(N), .H_TILE(1), .P_TILE(1), .N_TILE(N_TILE), .M_LAT(M_LAT), .CREDITS(CREDITS)) dut (
    .clk(clk), .rstn(rstn), .start_i(start_i), .busy_o(busy_o), .done_o(done_o), .rd_en_o(rd_en_o),
    .dx_addr_o(dx_addr_o), .b_addr_o(b_addr_o), .mul_valid_o(mul_valid_o), .mul_valid_i(mul_valid_i),
    .out_valid_o(out_valid_o), .out_h_o(out_h_o), .out_p_o(out_p_o), .out_n_o(out_n_o),
    .out_last_o(out_last_o), .credit_ret_i(credit_ret_i), .err_o(err_o)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk or negedge rstn)
    if (!rstn) pipe <= '0;
    else pipe <= {pipe[M_LAT-2:0], mul_valid_o};
  assign mul_valid_i = pipe[M_LAT-1] | spur;
  assign credit_ret_i = man_ret | (auto_ret & rd_en_o);
  task automatic chk(input string nm, input int act, input int want);
    checks++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, want, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (!rstn) begin
      chk("rst_rd_en", rd_en_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_mul_valid", mul_valid_o, 0);
      chk("rst_out_valid", out_valid_o, 0);
      chk("rst_err", err_o, 0);
      chk("rst_addr", {dx_addr_o, b_addr_o}, 0);
      chk("rst_out_tag", {out_h_o, out_p_o, out_n_o, out_last_o}, 0);
      mphase = 0; k = 0; credits = CREDITS; prev_iss = 0; merr = 0; q.delete();
    end else begin
      exp_rd = (mphase == 1 && credits > 0) ? 1 : 0;
      exp_done = (mphase == 2 && q.size() == 0) ? 1 : 0;
      chk("rd_en", rd_en_o, exp_rd);
      chk("busy", busy_o, mphase != 0);
      chk("done", done_o, exp_done);
      chk("mul_valid", mul_valid_o, prev_iss);
      chk("err", err_o, merr);
      chk("out_valid", out_valid_o, mul_valid_i);
      if (rd_en_o) begin
        n_iss++;
        iss_dx.push_back(int'(dx_addr_o));
        iss_b.push_back(int'(b_addr_o));
      end
      if (done_o) begin
        n_done++;
        done_lat = cyc - start_cyc;
      end
      if (start_i && !busy_o) start_cyc = cyc;
      if (exp_rd) begin
        chk("dx_addr", dx_addr_o, k / NN);
        chk("b_addr", b_addr_o, k % NN);
      end
      if (mul_valid_i) begin
        if (q.size() > 0) begin
          tg = q.pop_front();
          chk("out_h", out_h_o, tg.h);
          chk("out_p", out_p_o, tg.p);
          chk("out_n", out_n_o, tg.n);
          chk("out_last", out_last_o, tg.last);
          if (out_last_o) last_idx = n_out;
          n_out++;
        end else begin
          chk("spur_tag", {out_h_o, out_p_o, out_n_o, out_last_o}, 0);
          merr = 1;
        end
      end
      if (exp_rd) begin
        q.push_back('{h: k / (NP * NN), p: (k / NN) % NP, n: k % NN, last: k == T - 1});
        if (k == T - 1) mphase = 2;
        k++;
        if (!credit_ret_i) credits--;
      end else if (credit_ret_i) begin
        if (credits == CREDITS) merr = 1;
        else credits++;
      end
      if (exp_done) mphase = 0;
      else if (mphase == 0 && start_i) begin
        mphase = 1;
        k = 0;
      end
      prev_iss = exp_rd;
    end
  end
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic clear_logs;
    iss_dx.delete();
    iss_b.delete();
    n_out = 0;
    last_idx = -1;
  endtask
  task automatic pulse_start;
    start_i = 1;
    step(1);
    start_i = 0;
  endtask
  task automatic run_until_done(input int lim);
    int i = 0;
    while (!done_o && i < lim) begin
      step(1);
      i++;
    end
    chk("done_seen", int'(done_o), 1);
    step(1);
  endtask
  task automatic check_seq;
    chk("seq_len", iss_dx.size(), T);
    for (int i = 0; i < T && i < iss_dx.size(); i++) begin
      chk("seq_dx", iss_dx[i], exp_dx[i]);
      chk("seq_b", iss_b[i], exp_b[i]);
    end
    chk("last_pos", last_idx, T - 1);
  endtask
  initial begin
    int d0, i0;
    step(3);
    rstn = 1;
    step(2);
    clear_logs(); d0 = n_done; auto_ret = 1;
    pulse_start();
    run_until_done(60);
    check_seq();
    chk("latency", done_lat, 16);
    chk("done_once", n_done - d0, 1);
    clear_logs(); d0 = n_done;
    pulse_start();
    step(2);
    pulse_start();
    step(7);
    pulse_start();
    run_until_done(60);
    step(3);
    check_seq();
    chk("restart_latency", done_lat, 16);
    chk("restart_done_once", n_done - d0, 1);
    chk("restart_idle", busy_o, 0);
    auto_ret = 0; clear_logs();
    pulse_start();
    run_until_done(60);
    check_seq();
    man_ret = 1;
    step(2);
    man_ret = 0;
    clear_logs(); i0 = n_iss;
    pulse_start();
    step(10);
    chk("stall_issues", n_iss - i0, 2);
    chk("stall_rd", rd_en_o, 0);
    man_ret = 1;
    step(1);
    man_ret = 0;
    chk("one_more_rd", rd_en_o, 1);
    step(1);
    chk("one_more_off", rd_en_o, 0);
    chk("one_more_cnt", n_iss - i0, 3);
    man_ret = 1;
    step(1);
    chk("b2b_first", rd_en_o, 1);
    step(1);
    man_ret = 0;
    chk("b2b_second", rd_en_o, 1);
    step(1);
    chk("b2b_stop", rd_en_o, 0);
    chk("b2b_cnt", n_iss - i0, 5);
    man_ret = 1;
    step(3);
    man_ret = 0;
    run_until_done(60);
    chk("credit_sweep_cnt", n_iss - i0, 8);
    check_seq();
    man_ret = 1;
    step(4);
    man_ret = 0; auto_ret = 1; d0 = n_done;
    pulse_start();
    step(3);
    chk("t3_rd", rd_en_o, 1);
    chk("t3_dx", dx_addr_o, 1);
    chk("t3_b", b_addr_o, 1);
    #1 rstn = 0;
    #1;
    chk("async_rd", rd_en_o, 0);
    chk("async_busy", busy_o, 0);
    chk("async_mul_valid", mul_valid_o, 0);
    step(2);
    rstn = 1;
    step(10);
    chk("no_done_after_rst", n_done - d0, 0);
    clear_logs();
    pulse_start();
    run_until_done(60);
    chk("restart_dx0", iss_dx[0], 0);
    chk("restart_b0", iss_b[0], 0);
    check_seq();
    spur = 1;
    step(1);
    spur = 0;
    chk("spur_err", err_o, 1);
    step(5);
    chk("spur_err_sticky", err_o, 1);
    rstn = 0;
    step(2);
    rstn = 1;
    step(1);
    chk("err_cleared", err_o, 0);
    auto_ret = 0; man_ret = 1;
    step(1);
    man_ret = 0;
    chk("excess_err", err_o, 1);
    clear_logs();
    pulse_start();
    run_until_done(60);
    check_seq();
    i0 = n_iss;
    pulse_start();
    step(10);
    chk("sat_issues", n_iss - i0, 0);
    chk("sat_busy", busy_o, 1);
    chk("sat_err_sticky", err_o, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
